// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - control and round-key stream bundle for aes_key_sched_ctrl; abort wires exist only with AES_KS_ABORT_EN
interface aes_key_sched_ctrl_if;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic [3:0]   nr;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
`ifdef AES_KS_ABORT_EN
    logic         abort;

    modport master (
        output start, mode, key, rk_ready, abort,
        input  busy, done, nr, rk_valid, rk_data, rk_index
    );

    modport slave (
        input  start, mode, key, rk_ready, abort,
        output busy, done, nr, rk_valid, rk_data, rk_index
    );
`else
    modport master (
        output start, mode, key, rk_ready,
        input  busy, done, nr, rk_valid, rk_data, rk_index
    );

    modport slave (
        input  start, mode, key, rk_ready,
        output busy, done, nr, rk_valid, rk_data, rk_index
    );
`endif
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128/192/256 key schedule, one word per cycle; AES_KS_ABORT_EN adds abort
module aes_key_sched_ctrl (
    input  logic               clk,
    input  logic               rst,
    aes_key_sched_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Byte x sits at index ~x so the table reads in natural order below.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {SBOX[~w[31:24]], SBOX[~w[23:16]], SBOX[~w[15:8]], SBOX[~w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t           state;
    logic [255:0]     key_q;
    logic [7:0][31:0] win;
    logic [3:0]       nk_q;
    logic [5:0]       widx;
    logic [5:0]       last_idx;
    logic [3:0]       pos;
    logic [7:0]       rcon;
    logic [31:0]      stage0;
    logic [31:0]      stage1;
    logic [31:0]      stage2;
    logic             done_pend;

    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] w_new;
    logic        from_key;
    logic        rcon_step;
    logic        completes;
    logic        handshake;
    logic        produce;

    // win[0] is w[i-1]; w[i-Nk] is picked by the latched key length.
    always_comb begin
        w_prev = win[0];
        case (nk_q)
            4'd6:    w_old = win[5];
            4'd8:    w_old = win[7];
            default: w_old = win[3];
        endcase
        from_key  = widx < {2'b00, nk_q};
        rcon_step = !from_key && (pos == 4'd0);
        sub_in    = rcon_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        sub_out   = subword(sub_in);
        if (from_key) begin
            w_new = key_q[255:224];
        end else if (rcon_step) begin
            w_new = w_old ^ sub_out ^ {rcon, 24'h000000};
        end else if ((nk_q == 4'd8) && (pos == 4'd4)) begin
            w_new = w_old ^ sub_out;
        end else begin
            w_new = w_old ^ w_prev;
        end
    end

    assign completes = (widx[1:0] == 2'b11);
    assign handshake = bus.rk_valid && bus.rk_ready;
    // Only the word that finishes a round key waits on a full output register.
    assign produce   = (state == RUN) && !(completes && bus.rk_valid && !bus.rk_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            key_q        <= '0;
            win          <= '0;
            nk_q         <= 4'd4;
            widx         <= '0;
            last_idx     <= 6'd43;
            pos          <= '0;
            rcon         <= 8'h01;
            stage0       <= '0;
            stage1       <= '0;
            stage2       <= '0;
            done_pend    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.nr       <= 4'd10;
            bus.rk_valid <= 1'b0;
            bus.rk_data  <= '0;
            bus.rk_index <= '0;
        end else begin
            bus.done  <= done_pend;
            done_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.mode)
                            2'b01: begin
                                nk_q     <= 4'd6;
                                bus.nr   <= 4'd12;
                                last_idx <= 6'd51;
                                key_q    <= {bus.key[191:0], 64'h0};
                            end
                            2'b10: begin
                                nk_q     <= 4'd8;
                                bus.nr   <= 4'd14;
                                last_idx <= 6'd59;
                                key_q    <= bus.key;
                            end
                            default: begin
                                nk_q     <= 4'd4;
                                bus.nr   <= 4'd10;
                                last_idx <= 6'd43;
                                key_q    <= {bus.key[127:0], 128'h0};
                            end
                        endcase
                        widx     <= '0;
                        pos      <= '0;
                        rcon     <= 8'h01;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        bus.rk_valid <= 1'b0;
                    end
                    if (produce) begin
                        win   <= {win[6:0], w_new};
                        key_q <= {key_q[223:0], 32'h0};
                        widx  <= widx + 6'd1;
                        pos   <= (pos == nk_q - 4'd1) ? 4'd0 : pos + 4'd1;
                        if (rcon_step) begin
                            rcon <= xtime(rcon);
                        end
                        case (widx[1:0])
                            2'b00:   stage0 <= w_new;
                            2'b01:   stage1 <= w_new;
                            2'b10:   stage2 <= w_new;
                            default: begin
                                bus.rk_data  <= {stage0, stage1, stage2, w_new};
                                bus.rk_valid <= 1'b1;
                                bus.rk_index <= widx[5:2];
                            end
                        endcase
                        if (widx == last_idx) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        bus.rk_valid <= 1'b0;
                        bus.busy     <= 1'b0;
                        done_pend    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AES_KS_ABORT_EN
            if (bus.abort && (state != IDLE)) begin
                state        <= IDLE;
                bus.busy     <= 1'b0;
                bus.rk_valid <= 1'b0;
                done_pend    <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - scoreboard bench for aes_key_sched_ctrl against an independent key-expansion model
module tb_aes_key_sched_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [255:0] KEY_FIPS = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] KEY_128  = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] KEY_192  = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [255:0] KEY_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int hs_count, done_count, done_rel, last_rel, exp_nr;
    int lo_from = -1;
    int lo_to = -1;
    bit ready_en = 1'b0;

    logic [127:0] sb_data [$];
    logic [3:0]   sb_idx [$];
    logic [127:0] cap [0:15];
    logic [31:0]  mw [0:59];
    int           mnr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from the field inverse plus affine map, not a table.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] base = x;
        logic [7:0] e = 8'd254;
        logic [7:0] r;
        logic [7:0] s;
        for (int k = 0; k < 8; k++) begin
            if (e[0]) inv = gmul(inv, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        s = inv ^ 8'h63;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s;
    endfunction

    function automatic logic [31:0] sub4(input logic [31:0] w);
        return {sbox_calc(w[31:24]), sbox_calc(w[23:16]), sbox_calc(w[15:8]), sbox_calc(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] k, input logic [1:0] m);
        int nk;
        logic [31:0] t;
        logic [7:0] rc;
        nk  = (m == 2'b01) ? 6 : (m == 2'b10) ? 8 : 4;
        mnr = nk + 6;
        rc  = 8'h01;
        for (int i = 0; i < 4 * (mnr + 1); i++) begin
            if (i < nk) begin
                mw[i] = k[32 * (nk - i) - 1 -: 32];
            end else begin
                t = mw[i - 1];
                if (i % nk == 0) begin
                    t = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % 8 == 4) begin
                    t = sub4(t);
                end
                mw[i] = mw[i - nk] ^ t;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                done_count++;
                done_rel = cyc - start_cyc;
            end
            if (bus.rk_valid && (int'(bus.rk_index) == exp_nr) && last_rel < 0)
                last_rel = cyc - start_cyc;
            if (bus.rk_valid && !bus.rk_ready && sb_data.size() > 0) begin
                check("hold_data", bus.rk_data, sb_data[0]);
                check("hold_index", bus.rk_index, sb_idx[0]);
            end
            if (bus.rk_valid && bus.rk_ready) begin
                hs_count++;
                cap[bus.rk_index] = bus.rk_data;
                if (sb_data.size() > 0) begin
                    check("rk_data", bus.rk_data, sb_data.pop_front());
                    check("rk_index", bus.rk_index, sb_idx.pop_front());
                end
            end
        end
    end

    initial begin
        int rel;
        bus.rk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rel = cyc - start_cyc + 1;
            bus.rk_ready = ready_en && !(rel >= lo_from && rel <= lo_to);
        end
    end

    task automatic run(input logic [255:0] k, input logic [1:0] m, input int lf, input int lt);
        expand(k, m);
        sb_data.delete();
        sb_idx.delete();
        for (int r = 0; r <= mnr; r++) begin
            sb_data.push_back({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
            sb_idx.push_back(4'(r));
        end
        exp_nr = mnr;
        hs_count = 0;
        done_count = 0;
        done_rel = -1;
        last_rel = -1;
        for (int r = 0; r < 16; r++) cap[r] = '0;
        lo_from = -1;
        lo_to = -1;
        @(posedge clk);
        #1;
        bus.key = k;
        bus.mode = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        bus.key = ~k;
        bus.mode = m + 2'd1;
        lo_from = lf;
        lo_to = lt;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 400 && done_count == 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("done_count", done_count, 1);
        check("sb_empty", sb_data.size(), 0);
        check("busy_after", bus.busy, 0);
    endtask

    task automatic wait_rel(input int r);
        for (int n = 0; n < 200 && (cyc - start_cyc) < r; n++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.key = '0;
`ifdef AES_KS_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_en = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.rk_valid, 0);
        check("rst_data", bus.rk_data, 0);
        check("rst_index", bus.rk_index, 0);
        check("rst_nr", bus.nr, 10);

        run(KEY_FIPS, 2'b00, -1, -1);
        wait_rel(1);
        check("busy_edge1", bus.busy, 1);
        check("nr_128", bus.nr, 10);
        wait_done();
        check("rk0_128", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("rk1_128", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("rk10_128", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("last_edge_128", last_rel, 44);
        check("done_edge_128", done_rel, 46);
        check("hs_128", hs_count, 11);

        run(KEY_192, 2'b01, -1, -1);
        wait_rel(1);
        check("nr_192", bus.nr, 12);
        wait_done();
        check("rk12_192", cap[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
        check("last_edge_192", last_rel, 52);
        check("done_edge_192", done_rel, 54);
        check("hs_192", hs_count, 13);

        run(KEY_256, 2'b10, -1, -1);
        wait_rel(1);
        check("nr_256", bus.nr, 14);
        wait_done();
        check("rk14_256", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("last_edge_256", last_rel, 60);
        check("done_edge_256", done_rel, 62);
        check("hs_256", hs_count, 15);

        // RK3 held so the word completing RK4 waits seven cycles.
        run(KEY_FIPS, 2'b00, 17, 26);
        wait_done();
        check("rk10_bp", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("last_edge_bp", last_rel, 51);
        check("done_edge_bp", done_rel, 53);
        check("hs_bp", hs_count, 11);

        run(KEY_FIPS, 2'b00, -1, -1);
        wait_rel(10);
        @(posedge clk);
        #1;
        bus.key = KEY_256;
        bus.mode = 2'b10;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        check("nr_ignored_start", bus.nr, 10);
        check("done_edge_ign", done_rel, 46);
        check("hs_ign", hs_count, 11);

        run(KEY_FIPS, 2'b00, -1, -1);
        wait_rel(19);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_valid", bus.rk_valid, 0);
        check("midrst_data", bus.rk_data, 0);
        check("midrst_index", bus.rk_index, 0);
        check("midrst_nr", bus.nr, 10);
        sb_data.delete();
        sb_idx.delete();
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_count, 0);

        run(KEY_128, 2'b11, -1, -1);
        wait_done();
        check("nr_mode3", bus.nr, 10);
        check("rk10_after_rst", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

`ifdef AES_KS_ABORT_EN
        run(KEY_FIPS, 2'b00, -1, -1);
        wait_rel(12);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_valid", bus.rk_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_hs", hs_count, 3);
        sb_data.delete();
        sb_idx.delete();
        repeat (60) @(negedge clk);
        check("abort_no_done", done_count, 0);

        run(KEY_128, 2'b00, -1, -1);
        wait_done();
        check("rk0_restart", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("hs_restart", hs_count, 11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
